// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the 8-lane round-robin mux arbiter.
// Holds lane geometry, the FSM state encoding and the grant one-hot helper.
package mux_arb_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [NREQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick8.sv
// Combinational round-robin picker: first asserted request at or after ptr, cyclically.
// Scans a doubled request vector so the wrap-around needs no special case.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic       any,
    output logic [2:0] idx
);

    logic [2*NREQ-1:0] dbl;

    assign dbl = {req, req};

    // NOTE: every output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        any = 1'b0;
        idx = '0;
        // Walk from the farthest offset down so the nearest hit is the last one written.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (dbl[4'(ptr) + 4'(i)]) begin
                any = 1'b1;
                idx = ptr + 3'(i);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 bit mux; y is the registered d[sel].
// Define MUX_ARB_LOCK_EN to add a per-lane lock input that holds a grant past MAX_HOLD.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] d,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       gnt_valid,
    output logic       y
`ifdef MUX_ARB_LOCK_EN
    ,
    input  logic [7:0] lock
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              y_q, y_d;

    logic [SEL_W-1:0]  scan_base;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              lock_sel;
    logic              expiry;
    logic              release_now;

`ifdef MUX_ARB_LOCK_EN
    assign lock_sel = lock[sel_q];
`else
    assign lock_sel = 1'b0;
`endif

    // While granted, the scan already starts at sel+1 so a release re-grants with no bubble.
    assign scan_base = (state_q == ST_GRANT) ? sel_q + 3'd1 : ptr_q;

    rr_pick8 u_pick (
        .req (req),
        .ptr (scan_base),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign expiry      = (hold_cnt_q == HOLD_LAST) && !lock_sel;
    assign release_now = !req[sel_q] || expiry;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d     = ST_GRANT;
                    sel_d       = pick_idx;
                    gnt_d       = onehot8(pick_idx);
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    ptr_d      = sel_q + 3'd1;
                    hold_cnt_d = '0;
                    if (pick_any) begin
                        sel_d = pick_idx;
                        gnt_d = onehot8(pick_idx);
                    end else begin
                        // sel keeps its last value so downstream still sees the previous owner.
                        state_d     = ST_IDLE;
                        gnt_d       = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        y_d = gnt_valid_d ? d[sel_d] : 1'b0;
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            y_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            y_q         <= y_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = gnt_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (MAX_HOLD=4): reset, rotation, early release, wrap,
// data path, same-lane re-grant and, with MUX_ARB_LOCK_EN, the lock hold-extend.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       gnt_valid;
    logic       y;
`ifdef MUX_ARB_LOCK_EN
    logic [7:0] lock;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    mux_rr_arbiter #(
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d         (d),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .y         (y)
`ifdef MUX_ARB_LOCK_EN
        ,
        .lock      (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [7:0] exp_gnt,
                               input logic [2:0] exp_sel, input logic exp_valid);
        check({tag, ".gnt"}, gnt, exp_gnt);
        check({tag, ".sel"}, 8'(sel), 8'(exp_sel));
        check({tag, ".valid"}, 8'(gnt_valid), 8'(exp_valid));
    endtask

    initial begin
        logic [7:0] exp_g;
        int         lane;

        rst_n = 1'b0;
        req   = 8'hFF;
        d     = 8'h00;
`ifdef MUX_ARB_LOCK_EN
        lock  = 8'h00;
`endif

        // Reset holds everything at zero even with every lane requesting.
        step();
        step();
        check_grant("reset", 8'h00, 3'd0, 1'b0);
        check("reset.y", 8'(y), 8'h00);

        // Full rotation 0..7,0: each grant visible for exactly 4 cycles, no gaps.
        rst_n = 1'b1;
        for (int g = 0; g < 9; g++) begin
            lane  = g % 8;
            exp_g = 8'h01 << lane;
            for (int c = 0; c < 4; c++) begin
                step();
                check_grant($sformatf("rot_g%0d_c%0d", g, c), exp_g, 3'(lane), 1'b1);
            end
        end

        // Reset mid-grant drops the grant without waiting for a clock edge.
        rst_n = 1'b0;
        #1;
        check_grant("mid_reset", 8'h00, 3'd0, 1'b0);

        // Early release: lane 2 drops its request after 2 cycles, lane 5 follows at once.
        req   = 8'h24;
        rst_n = 1'b1;
        step();
        check_grant("early_g2", 8'h04, 3'd2, 1'b1);
        step();
        check_grant("early_g2_hold", 8'h04, 3'd2, 1'b1);
        req = 8'h20;
        step();
        check_grant("early_g5", 8'h20, 3'd5, 1'b1);
        req = 8'h00;
        step();
        check_grant("early_idle", 8'h00, 3'd5, 1'b0);

        // Move ptr to 7 via a short lane-6 grant, then wrap 7 -> 0.
        req = 8'h40;
        step();
        check_grant("wrap_g6", 8'h40, 3'd6, 1'b1);
        req = 8'h00;
        step();
        check_grant("wrap_idle6", 8'h00, 3'd6, 1'b0);
        req = 8'h81;
        step();
        check_grant("wrap_g7", 8'h80, 3'd7, 1'b1);
        req = 8'h01;
        step();
        check_grant("wrap_g0", 8'h01, 3'd0, 1'b1);
        req = 8'h00;
        step();
        check_grant("wrap_idle0", 8'h00, 3'd0, 1'b0);

        // Data path on lane 3: y follows d[3] only, and is forced low once idle.
        req = 8'h08;
        d   = 8'h08;
        step();
        check_grant("data_g3", 8'h08, 3'd3, 1'b1);
        check("data_y1", 8'(y), 8'h01);
        d = 8'h00;
        step();
        check("data_y0", 8'(y), 8'h00);
        d = 8'hF7;
        step();
        check("data_other_lanes", 8'(y), 8'h00);
        req = 8'h00;
        d   = 8'hFF;
        step();
        check_grant("data_idle", 8'h00, 3'd3, 1'b0);
        check("data_idle_y", 8'(y), 8'h00);
        d = 8'h00;

        // Lane 4 alone: expiry re-grants the same lane; a new lane-0 request waits for release.
        req = 8'h10;
        for (int c = 0; c < 5; c++) begin
            step();
            check_grant($sformatf("regrant_c%0d", c), 8'h10, 3'd4, 1'b1);
        end
        req = 8'h11;
        for (int c = 0; c < 3; c++) begin
            step();
            check_grant($sformatf("no_preempt_c%0d", c), 8'h10, 3'd4, 1'b1);
        end
        step();
        check_grant("after_release_g0", 8'h01, 3'd0, 1'b1);
        req = 8'h00;
        step();
        check_grant("final_idle", 8'h00, 3'd0, 1'b0);

`ifdef MUX_ARB_LOCK_EN
        // Lock on lane 0 keeps it past MAX_HOLD; dropping lock expires it to lane 1.
        rst_n = 1'b0;
        #1;
        req   = 8'h03;
        lock  = 8'h01;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check_grant($sformatf("lock_c%0d", c), 8'h01, 3'd0, 1'b1);
        end
        lock = 8'h00;
        step();
        check_grant("lock_release", 8'h02, 3'd1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
